// File: rtl/hash160_pkg.sv
// Shared constants, FSM state encoding and small helpers for the Hash160
// core byte-stream transmitter.
package hash160_pkg;

  localparam logic [7:0] START_TOKEN = 8'hAA;
  localparam logic [7:0] IDLE_BYTE   = 8'h00;
  localparam int         BLOCK_BYTES = 64;
  localparam int         BLOCK_W     = 512;
  localparam int         DIGEST_W    = 160;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CRST  = 3'd1,
    ST_GAP   = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_WAIT  = 3'd5,
    ST_RESP  = 3'd6
  } state_e;

  // Rising-edge detect between the current sample and the previous-cycle sample.
  function automatic logic valid_rise(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/hash160_byte_serializer.sv
// 512-bit block register that presents the most significant byte and shifts
// left by one byte per step, so byte 0 of the block leaves first.
module hash160_byte_serializer
  import hash160_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               shift_i,
  input  logic [BLOCK_W-1:0] blk_i,
  output logic [7:0]         byte_o
);

  logic [BLOCK_W-1:0] sr_q;

  // Block shift register: load on acceptance, otherwise advance one byte per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= blk_i;
    end else if (shift_i) begin
      sr_q <= {sr_q[BLOCK_W-9:0], 8'h00};
    end
  end

  assign byte_o = sr_q[BLOCK_W-1 -: 8];

endmodule

// File: rtl/hash160_stream_tx.sv
// Host-side transmitter for the Hash160 core: accepts one 512-bit block,
// resets the core, sends the start token and 64 data bytes, then waits for
// the core's done pulse and returns the digest (or a timeout error).
module hash160_stream_tx
  import hash160_pkg::*;
#(
  parameter int unsigned GAP_CYC     = 2,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BLOCK_W-1:0]  i_blk,
  input  logic                i_blk_valid,
  output logic                o_blk_ready,
  output logic                o_core_rst_n,
  output logic [7:0]          o_text,
  input  logic                i_valid,
  input  logic [DIGEST_W-1:0] i_answer,
  output logic [DIGEST_W-1:0] o_res,
  output logic                o_res_err,
  output logic                o_res_valid,
  input  logic                i_res_ready
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [5:0]       IDX_LAST = 6'(BLOCK_BYTES - 1);

  state_e                state_q;
  logic [7:0]            text_q;
  logic                  core_rst_n_q;
  logic [DIGEST_W-1:0]   res_q;
  logic                  res_err_q;
  logic                  res_valid_q;
  logic [GAP_W-1:0]      gap_cnt_q;
  logic [5:0]            idx_q;
  logic [TMO_W-1:0]      tmo_cnt_q;
  logic                  valid_prev_q;

  logic                  blk_hs_s;
  logic                  shift_s;
  logic                  valid_rise_s;
  logic [7:0]            ser_byte_s;

  assign o_blk_ready  = (state_q == ST_IDLE);
  assign blk_hs_s     = i_blk_valid & o_blk_ready;
  assign shift_s      = (state_q == ST_START) || (state_q == ST_DATA);
  assign valid_rise_s = valid_rise(i_valid, valid_prev_q);

  assign o_text       = text_q;
  assign o_core_rst_n = core_rst_n_q;
  assign o_res        = res_q;
  assign o_res_err    = res_err_q;
  assign o_res_valid  = res_valid_q;

  hash160_byte_serializer u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (blk_hs_s),
    .shift_i (shift_s),
    .blk_i   (i_blk),
    .byte_o  (ser_byte_s)
  );

  // Previous-cycle copy of the core done flag; runs in every state so a
  // level left high by an earlier job never looks like a fresh edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_prev_q <= 1'b0;
    end else begin
      valid_prev_q <= i_valid;
    end
  end

  // Framing FSM; outputs are loaded on the same edge as the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      text_q       <= IDLE_BYTE;
      core_rst_n_q <= 1'b1;
      res_q        <= '0;
      res_err_q    <= 1'b0;
      res_valid_q  <= 1'b0;
      gap_cnt_q    <= '0;
      idx_q        <= 6'd0;
      tmo_cnt_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (blk_hs_s) begin
            state_q      <= ST_CRST;
            core_rst_n_q <= 1'b0;
            text_q       <= IDLE_BYTE;
          end
        end
        ST_CRST: begin
          core_rst_n_q <= 1'b1;
          gap_cnt_q    <= '0;
          if (GAP_CYC == 0) begin
            state_q <= ST_START;
            text_q  <= START_TOKEN;
          end else begin
            state_q <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q <= ST_START;
            text_q  <= START_TOKEN;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        ST_START: begin
          state_q <= ST_DATA;
          text_q  <= ser_byte_s;
          idx_q   <= 6'd0;
        end
        ST_DATA: begin
          if (idx_q == IDX_LAST) begin
            state_q   <= ST_WAIT;
            text_q    <= IDLE_BYTE;
            tmo_cnt_q <= '0;
          end else begin
            text_q <= ser_byte_s;
            idx_q  <= idx_q + 6'd1;
          end
        end
        ST_WAIT: begin
          // A genuine edge takes priority over an expiring timeout.
          if (valid_rise_s) begin
            res_q       <= i_answer;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else if (tmo_cnt_q == TMO_LAST) begin
            res_q       <= '0;
            res_err_q   <= 1'b1;
            res_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          if (i_res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          text_q       <= IDLE_BYTE;
          core_rst_n_q <= 1'b1;
          res_valid_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hash160_stream_tx.sv
// Scoreboard bench for hash160_stream_tx with a behavioural Hash160 core model.
module tb_hash160_stream_tx;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [511:0] i_blk = '0;
  logic         i_blk_valid = 1'b0;
  logic         o_blk_ready;
  logic         o_core_rst_n;
  logic [7:0]   o_text;
  logic         i_valid = 1'b0;
  logic [159:0] i_answer = '0;
  logic [159:0] o_res;
  logic         o_res_err;
  logic         o_res_valid;
  logic         i_res_ready = 1'b1;

  int n_chk  = 0;
  int n_fail = 0;

  logic [160:0] sb[$];
  int           mode = 0;   // 0 normal core, 1 never done, 2 stale-high then pulse

  hash160_stream_tx #(.GAP_CYC(2), .TIMEOUT_CYC(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_blk        (i_blk),
    .i_blk_valid  (i_blk_valid),
    .o_blk_ready  (o_blk_ready),
    .o_core_rst_n (o_core_rst_n),
    .o_text       (o_text),
    .i_valid      (i_valid),
    .i_answer     (i_answer),
    .o_res        (o_res),
    .o_res_err    (o_res_err),
    .o_res_valid  (o_res_valid),
    .i_res_ready  (i_res_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [159:0] fold(input logic [511:0] b);
    logic [159:0] t;
    t = {b[31:0], 128'h0};
    return b[511:352] ^ b[351:192] ^ b[191:32] ^ t;
  endfunction

  function automatic logic [511:0] mk(input int kind);
    logic [511:0] b;
    logic [7:0]   v;
    for (int k = 0; k < 64; k++) begin
      case (kind)
        0: v = 8'(k);
        1: v = 8'hF0 ^ 8'(k * 3);
        2: v = 8'(k * 7 + 1);
        3: v = ~8'(k);
        4: v = 8'h55;
        5: v = 8'(k * 13) ^ 8'h3C;
        default: v = 8'hC3 - 8'(k);
      endcase
      b[511 - 8*k -: 8] = v;
    end
    return b;
  endfunction

  task automatic chk(input string nm, input logic [167:0] act, input logic [167:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural core: frames on 0xAA, takes 64 bytes, raises done later.
  int           m_st = 0;
  int           m_cnt = 0;
  int           m_post = 0;
  logic [511:0] m_buf = '0;
  always @(negedge clk) begin
    if (!rst_n || !o_core_rst_n) begin
      m_st = 0; m_cnt = 0; m_post = 0;
      i_valid = 1'b0; i_answer = '0;
    end else begin
      case (m_st)
        0: if (o_text == 8'hAA) begin m_st = 1; m_cnt = 0; end
        1: begin
          m_buf[511 - 8*m_cnt -: 8] = o_text;
          m_cnt++;
          if (mode == 2 && m_cnt == 60) begin
            i_valid = 1'b1; i_answer = {5{32'hDEADBEEF}};
          end
          if (m_cnt == 64) begin m_st = 2; m_post = 0; end
        end
        2: begin
          m_post++;
          if (mode == 0 && m_post == 5) begin
            i_valid = 1'b1; i_answer = fold(m_buf);
          end
          if (mode == 2 && m_post == 3) i_valid = 1'b0;
          if (mode == 2 && m_post == 5) begin
            i_valid = 1'b1; i_answer = fold(m_buf);
          end
        end
        default: m_st = 0;
      endcase
    end
  end

  // Monitor: pops an expectation when a result appears and checks it every held cycle.
  logic         mon_prev = 1'b0;
  logic         mon_have = 1'b0;
  logic [160:0] mon_exp = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_prev = 1'b0; mon_have = 1'b0;
    end else begin
      if (o_res_valid && !mon_prev) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++; mon_have = 1'b0;
          $display("FAIL unexpected_result actual=%0h required=none", {o_res_err, o_res});
        end else begin
          mon_exp = sb.pop_front(); mon_have = 1'b1;
        end
      end
      if (o_res_valid && mon_have) chk("result", {7'd0, o_res_err, o_res}, {7'd0, mon_exp});
      mon_prev = o_res_valid;
    end
  end

  // Offer a block, then walk ncyc cycles after the handshake checking the frame.
  task automatic send_block(input logic [511:0] blk, input int ncyc, input bit push,
                            input logic [160:0] exp, input bit chk_frame);
    int b = 0;
    logic [7:0] et;
    while (!o_blk_ready && b < 300) begin @(negedge clk); b++; end
    chk("blk_ready_wait", {167'd0, o_blk_ready}, 168'd1);
    i_blk = blk; i_blk_valid = 1'b1;
    if (push) sb.push_back(exp);
    @(posedge clk);
    for (int j = 1; j <= ncyc; j++) begin
      @(negedge clk);
      if (j == 1) begin
        i_blk_valid = 1'b0; i_blk = ~blk;
        chk("blk_ready_busy", {167'd0, o_blk_ready}, 168'd0);
      end
      if (chk_frame) begin
        if (j <= 3) et = 8'h00;
        else if (j == 4) et = 8'hAA;
        else et = blk[511 - 8*(j-5) -: 8];
        chk("core_rst_n", {167'd0, o_core_rst_n}, {167'd0, (j != 1)});
        chk("text", {160'd0, o_text}, {160'd0, et});
      end
    end
  endtask

  task automatic wait_idle();
    int b = 0;
    while (!(o_blk_ready && !o_res_valid && sb.size() == 0) && b < 300) begin
      @(negedge clk); b++;
    end
    chk("job_done", {167'd0, (b < 300)}, 168'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] blk;
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_text", {160'd0, o_text}, 168'd0);
    chk("rst_core_rst_n", {167'd0, o_core_rst_n}, 168'd1);
    chk("rst_res_valid", {167'd0, o_res_valid}, 168'd0);
    chk("rst_blk_ready", {167'd0, o_blk_ready}, 168'd1);
    chk("rst_res", {7'd0, o_res_err, o_res}, 168'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Normal job: bytes 00..3F
    mode = 0;
    blk = mk(0);
    send_block(blk, 68, 1'b1, {1'b0, fold(blk)}, 1'b1);
    wait_idle();

    // Timeout: core never finishes, 16 WAIT cycles
    mode = 1;
    blk = mk(1);
    send_block(blk, 68, 1'b1, {1'b1, 160'd0}, 1'b1);
    for (int j = 69; j <= 85; j++) begin
      @(negedge clk);
      if (j == 84) chk("tmo_not_yet", {167'd0, o_res_valid}, 168'd0);
      if (j == 85) chk("tmo_valid", {167'd0, o_res_valid}, 168'd1);
    end
    wait_idle();

    // Result held 20 cycles; competing block ignored until handshake
    mode = 0;
    i_res_ready = 1'b0;
    blk = mk(2);
    send_block(blk, 68, 1'b1, {1'b0, fold(blk)}, 1'b0);
    for (int b = 0; b < 100 && !o_res_valid; b++) @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      i_blk = mk(3); i_blk_valid = 1'b1;
      chk("hold_valid", {167'd0, o_res_valid}, 168'd1);
      chk("hold_blk_ready", {167'd0, o_blk_ready}, 168'd0);
      @(negedge clk);
    end
    i_res_ready = 1'b1;
    @(negedge clk);
    chk("resp_release", {166'd0, o_res_valid, o_blk_ready}, 168'd1);
    blk = mk(3);
    send_block(blk, 68, 1'b1, {1'b0, fold(blk)}, 1'b1);
    wait_idle();

    // Async reset during data byte 30
    blk = mk(4);
    send_block(blk, 35, 1'b0, 161'd0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_text", {160'd0, o_text}, 168'd0);
    chk("midrst_state", {165'd0, o_core_rst_n, o_blk_ready, o_res_valid}, 168'd6);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    blk = mk(5);
    send_block(blk, 68, 1'b1, {1'b0, fold(blk)}, 1'b1);
    wait_idle();

    // Stale-high done flag, then low/high pulse
    mode = 2;
    blk = mk(6);
    send_block(blk, 68, 1'b1, {1'b0, fold(blk)}, 1'b0);
    wait_idle();

    chk("sb_empty", 168'(sb.size()), 168'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
